// File: rtl/keycode_pkg.sv
// Shared types and constants for the HID boot-keyboard report parser.
// Optional macro KEYCODE_PRESS_EVENT_EN is consumed by the top module only.
package keycode_pkg;

    localparam int REPORT_BYTES = 8;
    localparam int KC_WIDTH     = 8;
    localparam int KEY_OUTS     = 2;
    localparam int IDX_W        = $clog2(REPORT_BYTES);

    typedef logic [7:0] keycode_t;

    localparam keycode_t KC_NONE         = 8'h00;
    localparam keycode_t KC_ERR_ROLLOVER = 8'h01;
    localparam keycode_t KC_POST_FAIL    = 8'h02;
    localparam keycode_t KC_ERR_UNDEF    = 8'h03;

    typedef enum logic [1:0] {
        WAIT_SOF,
        RSVD,
        KEYS,
        PUBLISH
    } parser_state_t;

    // Slot codes that carry no key: none, POST fail, undefined error.
    function automatic logic is_empty_code(input keycode_t code);
        return (code == KC_NONE) || (code == KC_POST_FAIL) || (code == KC_ERR_UNDEF);
    endfunction

endpackage

// File: rtl/key_slot_capture.sv
// Shadow capture of the first two distinct keycodes and the rollover flag
// for the report currently being received.
module key_slot_capture
    import keycode_pkg::*;
(
    input  logic     clk,
    input  logic     rst_n,
    input  logic     clear,
    input  logic     slot_valid,
    input  keycode_t code,
    output keycode_t shadow_k0,
    output keycode_t shadow_k1,
    output logic     shadow_roll
);

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            shadow_k0   <= KC_NONE;
            shadow_k1   <= KC_NONE;
            shadow_roll <= 1'b0;
        end else if (clear) begin
            shadow_k0   <= KC_NONE;
            shadow_k1   <= KC_NONE;
            shadow_roll <= 1'b0;
        end else if (slot_valid) begin
            if (code == KC_ERR_ROLLOVER) begin
                shadow_roll <= 1'b1;
            end else if (!is_empty_code(code)) begin
                if (shadow_k0 == KC_NONE) begin
                    shadow_k0 <= code;
                end else if ((shadow_k1 == KC_NONE) && (code != shadow_k0)) begin
                    shadow_k1 <= code;
                end
            end
        end
    end

endmodule

// File: rtl/keycode_report_parser.sv
// Parses 8-byte HID boot-keyboard reports and publishes modifiers plus two
// keycodes atomically per report. Optional: KEYCODE_PRESS_EVENT_EN.
module keycode_report_parser
    import keycode_pkg::*;
(
    input  logic                CLK,
    input  logic                Reset,
    input  logic [KC_WIDTH-1:0] byte_in,
    input  logic                byte_valid,
    input  logic                byte_sof,
    output logic                byte_ready,
    output keycode_t            keycode0,
    output keycode_t            keycode1,
    output keycode_t            modifiers,
    output logic                report_strobe,
    output logic                rollover_err,
`ifdef KEYCODE_PRESS_EVENT_EN
    output keycode_t            press_code,
    output logic                press_strobe,
`endif
    output parser_state_t       state_dbg
);

    localparam logic [IDX_W-1:0] LAST_IDX = IDX_W'(REPORT_BYTES - 1);

    // Handshake: a byte transfers on a rising edge where byte_valid && byte_ready;
    // byte_ready depends only on state, never on byte_valid.
    parser_state_t    state, state_next;
    logic [IDX_W-1:0] idx, idx_next;
    keycode_t         shadow_mod, shadow_mod_next;
    keycode_t         shadow_k0, shadow_k1;
    logic             shadow_roll;
    logic             accept, clear, slot_valid, publish;

    assign byte_ready = (state != PUBLISH);
    assign accept     = byte_valid && byte_ready;
    assign state_dbg  = state;

    key_slot_capture u_slots (
        .clk         (CLK),
        .rst_n       (Reset),
        .clear       (clear),
        .slot_valid  (slot_valid),
        .code        (byte_in),
        .shadow_k0   (shadow_k0),
        .shadow_k1   (shadow_k1),
        .shadow_roll (shadow_roll)
    );

    always_ff @(posedge CLK or negedge Reset) begin
        if (!Reset) begin
            state      <= WAIT_SOF;
            idx        <= '0;
            shadow_mod <= KC_NONE;
        end else begin
            state      <= state_next;
            idx        <= idx_next;
            shadow_mod <= shadow_mod_next;
        end
    end

    always_comb begin
        state_next      = state;
        idx_next        = idx;
        shadow_mod_next = shadow_mod;
        clear           = 1'b0;
        slot_valid      = 1'b0;
        publish         = 1'b0;
        // A SOF byte restarts a report from any accepting state, aborting a partial one.
        if (accept && byte_sof) begin
            shadow_mod_next = byte_in;
            clear           = 1'b1;
            idx_next        = IDX_W'(1);
            state_next      = RSVD;
        end else begin
            case (state)
                WAIT_SOF: ;
                RSVD: begin
                    if (accept) begin
                        idx_next   = IDX_W'(2);
                        state_next = KEYS;
                    end
                end
                KEYS: begin
                    if (accept) begin
                        slot_valid = 1'b1;
                        if (idx == LAST_IDX) begin
                            idx_next   = '0;
                            state_next = PUBLISH;
                        end else begin
                            idx_next = idx + 1'b1;
                        end
                    end
                end
                PUBLISH: begin
                    publish    = 1'b1;
                    state_next = WAIT_SOF;
                end
                default: state_next = WAIT_SOF;
            endcase
        end
    end

`ifdef KEYCODE_PRESS_EVENT_EN
    logic     press_hit;
    keycode_t press_val;

    // Newly pressed key relative to the pair currently on the outputs.
    always_comb begin
        press_hit = 1'b0;
        press_val = KC_NONE;
        if (!shadow_roll) begin
            if ((shadow_k0 != KC_NONE) && (shadow_k0 != keycode0) && (shadow_k0 != keycode1)) begin
                press_hit = 1'b1;
                press_val = shadow_k0;
            end else if ((shadow_k1 != KC_NONE) && (shadow_k1 != keycode0) && (shadow_k1 != keycode1)) begin
                press_hit = 1'b1;
                press_val = shadow_k1;
            end
        end
    end

    always_ff @(posedge CLK or negedge Reset) begin
        if (!Reset) begin
            press_code   <= KC_NONE;
            press_strobe <= 1'b0;
        end else begin
            press_strobe <= publish && press_hit;
            if (publish && press_hit) begin
                press_code <= press_val;
            end
        end
    end
`endif

    // Rollover reports refresh modifiers and the error flag but keep the last key pair.
    always_ff @(posedge CLK or negedge Reset) begin
        if (!Reset) begin
            keycode0      <= KC_NONE;
            keycode1      <= KC_NONE;
            modifiers     <= KC_NONE;
            rollover_err  <= 1'b0;
            report_strobe <= 1'b0;
        end else begin
            report_strobe <= publish;
            if (publish) begin
                modifiers    <= shadow_mod;
                rollover_err <= shadow_roll;
                if (!shadow_roll) begin
                    keycode0 <= shadow_k0;
                    keycode1 <= shadow_k1;
                end
            end
        end
    end

endmodule
